// File: rtl/calc_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_core_pkg
// Description : Shared key codes, operator and state encodings for the
//               calculator sequencer and its multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_core_pkg;

    // Keypad codes above the digits 0-9
    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    // Largest value the four-digit display can show
    localparam int DEFAULT_MAX_VAL = 9999;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_ENTRY_A = 2'd0,
        ST_ENTRY_B = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_RESULT  = 2'd3
    } state_e;

    // Map an operator key (A-D) onto the operator encoding
    function automatic op_e key_to_op(input logic [3:0] k);
        op_e v;
        case (k)
            KEY_SUB: v = OP_SUB;
            KEY_MUL: v = OP_MUL;
            KEY_DIV: v = OP_DIV;
            default: v = OP_ADD;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : seq_muldiv
// Description : Sequential NUM_W-cycle shift-add multiplier and restoring
//               divider. A divide by zero finishes one cycle after start.
//               done/result/ovf/div0 are valid in the cycle the last step
//               is being performed, so the caller can register them on the
//               same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv
    import calc_core_pkg::*;
#(
    parameter int NUM_W   = 14,
    parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  op_e              op,
    input  logic [NUM_W-1:0] a,
    input  logic [NUM_W-1:0] b,
    output logic             done,
    output logic [NUM_W-1:0] result,
    output logic             ovf,
    output logic             div0
);

    localparam int PW    = 2 * NUM_W;
    localparam int CNT_W = $clog2(NUM_W);

    logic             r_run;
    logic             r_is_div;
    logic             r_div0;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_prod;
    logic [PW-1:0]    r_mcand;
    logic [NUM_W-1:0] r_mplier;
    logic             r_ovf;
    logic [NUM_W-1:0] r_rem;
    logic [NUM_W-1:0] r_quo;
    logic [NUM_W-1:0] r_dvsr;

    logic [PW-1:0]    w_prod_sum;
    logic             w_ovf_nxt;
    logic [NUM_W:0]   w_rem_shift;
    logic [NUM_W:0]   w_rem_diff;
    logic             w_rem_ge;
    logic [NUM_W-1:0] w_rem_nxt;
    logic [NUM_W-1:0] w_quo_nxt;
    logic             w_last;

    // One multiply step: add the shifted multiplicand when the current B bit is set
    assign w_prod_sum = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_ovf_nxt  = r_ovf | (w_prod_sum > PW'(MAX_VAL));

    // One restoring-divide step; the sign of the trial difference decides the quotient bit
    assign w_rem_shift = {r_rem, r_quo[NUM_W-1]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_dvsr};
    assign w_rem_ge    = ~w_rem_diff[NUM_W];
    assign w_rem_nxt   = w_rem_ge ? w_rem_diff[NUM_W-1:0] : w_rem_shift[NUM_W-1:0];
    assign w_quo_nxt   = {r_quo[NUM_W-2:0], w_rem_ge};

    assign w_last = (r_cnt == CNT_W'(NUM_W - 1));
    assign done   = r_run & (r_div0 | w_last);
    assign result = r_div0 ? '0 : (r_is_div ? w_quo_nxt : w_prod_sum[NUM_W-1:0]);
    assign ovf    = ~r_is_div & w_ovf_nxt;
    assign div0   = r_div0;

    // Load operands on start, then advance one bit per cycle until done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_ovf    <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
        end else if (start) begin
            r_run    <= 1'b1;
            r_is_div <= (op == OP_DIV);
            r_div0   <= (op == OP_DIV) && (b == '0);
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= PW'(a);
            r_mplier <= b;
            r_ovf    <= 1'b0;
            r_rem    <= '0;
            r_quo    <= a;
            r_dvsr   <= b;
        end else if (r_run) begin
            if (done) begin
                r_run <= 1'b0;
            end
            r_cnt    <= r_cnt + 1'b1;
            r_prod   <= w_prod_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_ovf    <= w_ovf_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_core.sv
`default_nettype none
// ============================================================================
// Module      : calc_core
// Description : Calculator sequencer. Collects two decimal operands from
//               keypad events, runs + - * /, and strobes num/error into the
//               downstream binary-to-digit converter with a one-cycle convert.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_core
    import calc_core_pkg::*;
#(
    parameter int NUM_W      = 14,
    parameter int MAX_DIGITS = 4,
    parameter int MAX_VAL    = DEFAULT_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [NUM_W-1:0] num,
    output logic             error,
    output logic             convert,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    state_e           r_state;
    op_e              r_op;
    logic [NUM_W-1:0] r_a;
    logic [NUM_W-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;

    logic             w_key_digit;
    logic             w_key_op;
    logic             w_key_eq;
    logic             w_key_clr;
    logic [NUM_W-1:0] w_acc;
    logic [NUM_W-1:0] w_acc_nxt;
    logic [NUM_W-1:0] w_digit;
    logic             w_digit_ok;
    logic             w_eq_go;
    logic             w_eng_start;
    logic [NUM_W:0]   w_sum;
    logic             w_fin;
    logic             w_fin_err;
    logic [NUM_W-1:0] w_fin_val;

    logic             w_eng_done;
    logic [NUM_W-1:0] w_eng_result;
    logic             w_eng_ovf;
    logic             w_eng_div0;

    assign w_key_digit = (key_code <= 4'd9);
    assign w_key_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    assign w_key_eq    = (key_code == KEY_EQ);
    assign w_key_clr   = (key_code == KEY_CLR);

    // Decimal shift-in of the operand currently being entered: acc*10 + d
    assign w_digit    = NUM_W'(key_code);
    assign w_acc      = (r_state == ST_ENTRY_B) ? r_b : r_a;
    assign w_acc_nxt  = (w_acc << 3) + (w_acc << 1) + w_digit;
    assign w_digit_ok = (r_cnt < CNT_W'(MAX_DIGITS));

    // Equals is only honoured once B has at least one digit
    assign w_eq_go     = key_valid && w_key_eq && !w_key_clr &&
                         (r_state == ST_ENTRY_B) && (r_cnt != '0);
    assign w_eng_start = w_eq_go && ((r_op == OP_MUL) || (r_op == OP_DIV));

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    // Completion condition and result of the current COMPUTE cycle
    always_comb begin
        w_fin     = 1'b0;
        w_fin_err = 1'b0;
        w_fin_val = '0;
        case (r_op)
            OP_ADD: begin
                w_fin     = 1'b1;
                w_fin_err = (w_sum > (NUM_W + 1)'(MAX_VAL));
                w_fin_val = w_sum[NUM_W-1:0];
            end
            OP_SUB: begin
                w_fin     = 1'b1;
                w_fin_err = (r_b > r_a);
                w_fin_val = r_a - r_b;
            end
            default: begin
                w_fin     = w_eng_done;
                w_fin_err = w_eng_ovf | w_eng_div0;
                w_fin_val = w_eng_result;
            end
        endcase
    end

    seq_muldiv #(
        .NUM_W   (NUM_W),
        .MAX_VAL (MAX_VAL)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_eng_start),
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .done   (w_eng_done),
        .result (w_eng_result),
        .ovf    (w_eng_ovf),
        .div0   (w_eng_div0)
    );

    // Sequencer FSM with registered display outputs; clear overrides every state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ENTRY_A;
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            num     <= '0;
            error   <= 1'b0;
            convert <= 1'b0;
            busy    <= 1'b0;
        end else begin
            convert <= 1'b0;
            if (key_valid && w_key_clr) begin
                r_state <= ST_ENTRY_A;
                r_op    <= OP_ADD;
                r_a     <= '0;
                r_b     <= '0;
                r_cnt   <= '0;
                num     <= '0;
                error   <= 1'b0;
                convert <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_ENTRY_A, ST_ENTRY_B: begin
                        if (key_valid && w_key_digit) begin
                            if (w_digit_ok) begin
                                if (r_state == ST_ENTRY_B) begin
                                    r_b <= w_acc_nxt;
                                end else begin
                                    r_a <= w_acc_nxt;
                                end
                                r_cnt   <= r_cnt + 1'b1;
                                num     <= w_acc_nxt;
                                error   <= 1'b0;
                                convert <= 1'b1;
                            end
                        end else if (key_valid && w_key_op) begin
                            if (r_state == ST_ENTRY_A) begin
                                r_op    <= key_to_op(key_code);
                                r_b     <= '0;
                                r_cnt   <= '0;
                                r_state <= ST_ENTRY_B;
                            end else if (r_cnt == '0) begin
                                r_op <= key_to_op(key_code);
                            end
                        end else if (w_eq_go) begin
                            r_state <= ST_COMPUTE;
                            busy    <= 1'b1;
                        end
                    end
                    ST_COMPUTE: begin
                        if (w_fin) begin
                            r_state <= ST_RESULT;
                            r_a     <= w_fin_err ? '0 : w_fin_val;
                            r_b     <= '0;
                            r_cnt   <= '0;
                            num     <= w_fin_err ? '0 : w_fin_val;
                            error   <= w_fin_err;
                            convert <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                    ST_RESULT: begin
                        if (key_valid && w_key_digit) begin
                            r_a     <= w_digit;
                            r_b     <= '0;
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_ENTRY_A;
                            num     <= w_digit;
                            error   <= 1'b0;
                            convert <= 1'b1;
                        end else if (key_valid && w_key_op && !error) begin
                            r_op    <= key_to_op(key_code);
                            r_b     <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_ENTRY_B;
                        end
                    end
                    default: begin
                        r_state <= ST_ENTRY_A;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_core
// Description : Directed self-checking bench for calc_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_core;

    localparam int NUM_W = 14;

    logic             clk;
    logic             rst;
    logic             key_valid;
    logic [3:0]       key_code;
    logic [NUM_W-1:0] num;
    logic             error;
    logic             convert;
    logic             busy;

    int total = 0;
    int bad   = 0;

    calc_core #(
        .NUM_W      (NUM_W),
        .MAX_DIGITS (4),
        .MAX_VAL    (9999)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .num       (num),
        .error     (error),
        .convert   (convert),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Idle one cycle, then present a key for one cycle; returns at the
    // negedge where the resulting convert (if any) is visible.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic digit_echo(input string tag, input logic [3:0] k, input int v);
        press(k);
        chk({tag, ".conv"}, 32'(convert), 32'd1);
        chk({tag, ".num"},  32'(num), 32'(v));
        chk({tag, ".err"},  32'(error), 32'd0);
    endtask

    task automatic key_silent(input string tag, input logic [3:0] k);
        press(k);
        chk({tag, ".noconv"}, 32'(convert), 32'd0);
    endtask

    // Press equals, count cycles busy is high, then check the result strobe
    task automatic equals_result(input string tag, input int exp_busy, input int exp_num, input int exp_err);
        int n;
        press(4'hE);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 32'(n), 32'(exp_busy));
        chk({tag, ".conv"}, 32'(convert), 32'd1);
        chk({tag, ".num"},  32'(num), 32'(exp_num));
        chk({tag, ".err"},  32'(error), 32'(exp_err));
    endtask

    initial begin
        int nconv;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst.num",  32'(num), 32'd0);
        chk("rst.err",  32'(error), 32'd0);
        chk("rst.conv", 32'(convert), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // 12 + 34
        digit_echo("t1.d1", 4'h1, 1);
        digit_echo("t1.d2", 4'h2, 12);
        key_silent("t1.add", 4'hA);
        digit_echo("t1.d3", 4'h3, 3);
        digit_echo("t1.d4", 4'h4, 34);
        equals_result("t1.eq", 1, 46, 0);

        // 7 - 9 goes negative, then a digit restarts entry
        digit_echo("t2.d7", 4'h7, 7);
        key_silent("t2.sub", 4'hB);
        digit_echo("t2.d9", 4'h9, 9);
        equals_result("t2.eq", 1, 0, 1);
        digit_echo("t2.d5", 4'h5, 5);
        digit_echo("t2.d3", 4'h3, 53);
        press(4'hF);
        chk("t2.clr.conv", 32'(convert), 32'd1);
        chk("t2.clr.num",  32'(num), 32'd0);

        // 99 * 99, then 123 * 100 overflows
        digit_echo("t3.a1", 4'h9, 9);
        digit_echo("t3.a2", 4'h9, 99);
        key_silent("t3.mul", 4'hC);
        digit_echo("t3.b1", 4'h9, 9);
        digit_echo("t3.b2", 4'h9, 99);
        equals_result("t3.eq", NUM_W, 9801, 0);
        digit_echo("t3.c1", 4'h1, 1);
        digit_echo("t3.c2", 4'h2, 12);
        digit_echo("t3.c3", 4'h3, 123);
        key_silent("t3.mul2", 4'hC);
        digit_echo("t3.e1", 4'h1, 1);
        digit_echo("t3.e2", 4'h0, 10);
        digit_echo("t3.e3", 4'h0, 100);
        equals_result("t3.ovf", NUM_W, 0, 1);

        // 9999 / 7, then 100 / 0
        digit_echo("t4.a1", 4'h9, 9);
        digit_echo("t4.a2", 4'h9, 99);
        digit_echo("t4.a3", 4'h9, 999);
        digit_echo("t4.a4", 4'h9, 9999);
        key_silent("t4.div", 4'hD);
        digit_echo("t4.b1", 4'h7, 7);
        equals_result("t4.eq", NUM_W, 1428, 0);
        digit_echo("t4.c1", 4'h1, 1);
        digit_echo("t4.c2", 4'h0, 10);
        digit_echo("t4.c3", 4'h0, 100);
        key_silent("t4.div2", 4'hD);
        digit_echo("t4.z", 4'h0, 0);
        equals_result("t4.div0", 1, 0, 1);

        // Fifth digit ignored; op replaced while B empty
        digit_echo("t5.d1", 4'h1, 1);
        digit_echo("t5.d2", 4'h2, 12);
        digit_echo("t5.d3", 4'h3, 123);
        digit_echo("t5.d4", 4'h4, 1234);
        key_silent("t5.d5", 4'h5);
        chk("t5.d5.num", 32'(num), 32'd1234);
        key_silent("t5.add", 4'hA);
        key_silent("t5.mul", 4'hC);
        digit_echo("t5.b", 4'h2, 2);
        equals_result("t5.eq", NUM_W, 2468, 0);

        // Clear during a multiply aborts it
        digit_echo("t6.a", 4'h5, 5);
        key_silent("t6.mul", 4'hC);
        digit_echo("t6.b", 4'h6, 6);
        press(4'hE);
        chk("t6.busy1", 32'(busy), 32'd1);
        @(negedge clk);
        press(4'hF);
        chk("t6.clr.busy", 32'(busy), 32'd0);
        chk("t6.clr.conv", 32'(convert), 32'd1);
        chk("t6.clr.num",  32'(num), 32'd0);
        chk("t6.clr.err",  32'(error), 32'd0);
        nconv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (convert === 1'b1) nconv++;
        end
        chk("t6.no_late_result", 32'(nconv), 32'd0);
        chk("t6.idle.num", 32'(num), 32'd0);

        // Reset mid-entry clears outputs and the accumulator
        digit_echo("t7.d4", 4'h4, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("t7.rst.num",  32'(num), 32'd0);
        chk("t7.rst.err",  32'(error), 32'd0);
        chk("t7.rst.conv", 32'(convert), 32'd0);
        chk("t7.rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        digit_echo("t7.d7", 4'h7, 7);
        key_silent("t7.sub", 4'hB);
        digit_echo("t7.d3", 4'h3, 3);
        equals_result("t7.sub_ok", 1, 4, 0);

        // Chain an op from the result: 4 + 6
        key_silent("t8.add", 4'hA);
        digit_echo("t8.d6", 4'h6, 6);
        equals_result("t8.chain", 1, 10, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_core.md
Name: calc_core

Overview:
- Calculator sequencer, directly upstream of the binary-to-digit converter.
- Accepts decoded keypad events and accumulates two decimal operands.
- Executes +, -, *, / with multi-cycle sequential arithmetic.
- Presents a 14-bit unsigned value, an error flag and a one-cycle convert strobe, which drive the converter's num/error/convert inputs.

Parameters:
- NUM_W, 14, width of operands and result.
- MAX_DIGITS, 4, maximum decimal digits accepted per operand.
- MAX_VAL, 9999, largest displayable result; anything above is overflow.

Ports:
- clk  input  1  system clock; same clock as the downstream converter.
- rst  input  1  synchronous, active-high reset.
- key_valid  input  1  one-cycle key event strobe.
- key_code  input  4  key code:
  - 0-9: digit
  - A: add
  - B: subtract
  - C: multiply
  - D: divide
  - E: equals
  - F: clear
- num  output  NUM_W  value to display.
- error  output  1  result invalid; display error pattern.
- convert  output  1  one-cycle strobe; num/error are valid in the same cycle.
- busy  output  1  high while in COMPUTE.

Behaviour:
- Reset (synchronous on clk, active-high):
  - num=0, error=0, convert=0, busy=0.
  - State ENTRY_A; operands, op and digit count cleared.
- States: ENTRY_A, ENTRY_B, COMPUTE, RESULT.
- Clear key (F), in any state including COMPUTE:
  - Same effect as reset.
  - One cycle later, convert pulses with num=0, error=0.
- Digit key in ENTRY_A or ENTRY_B:
  - If digit count < MAX_DIGITS: acc = acc*10 + d, computed as (acc<<3)+(acc<<1)+d.
  - Otherwise the key is ignored, with no convert.
  - On an accepted digit: the next cycle has num=acc, error=0, convert=1 (echo).
- Op key (A-D):
  - In ENTRY_A: latch op, go to ENTRY_B with B=0 and count=0. No convert.
  - In ENTRY_B with count=0: replace op.
  - In ENTRY_B with count>0: ignored.
- Equals key (E):
  - Only acted on in ENTRY_B with count>0: go to COMPUTE and set busy=1.
  - Otherwise ignored.
- COMPUTE:
  - All keys except clear are ignored; key_valid is not queued.
  - add: 1 cycle; result=A+B; error if result>MAX_VAL.
  - sub: 1 cycle; error if B>A (no negatives).
  - mul: shift-add, one bit of B per cycle, NUM_W cycles. Error if any partial sum exceeds MAX_VAL; the product register is 2*NUM_W wide.
  - div: if B=0, error after 1 cycle. Otherwise restoring division, NUM_W cycles, quotient truncated (remainder discarded).
  - On completion: go to RESULT; the next cycle has num=result (0 if error), error as computed, convert=1, busy=0.
- RESULT:
  - Digit key starts a new ENTRY_A with A=d, count=1, and echoes it.
  - Op key with error=0: A=result, latch op, go to ENTRY_B.
  - Op key with error=1: ignored.
  - Equals key: ignored.
- Outputs num/error hold between convert strobes. convert is never high on two consecutive cycles.
- Latency from equals to convert:
  - add, sub, div-by-zero: 2 cycles.
  - mul, div: NUM_W+1 cycles.
- key_valid coincident with the convert cycle is processed normally; the input is independent of the output strobe.

Decomposition:
- Shared package:
  - key code constants (KEY_ADD=4'hA … KEY_CLR=4'hF)
  - op encoding (OP_ADD=2'd0, OP_SUB, OP_MUL, OP_DIV)
  - state encoding
  - MAX_VAL
- One sub-module: seq_muldiv.
  - Inputs: start, op, a, b.
  - Outputs: done, result, ovf, div0.
  - Runs the NUM_W-cycle shift-add and restoring-division engine.
  - calc_core retains the FSM, operand entry and output strobing.

Test Plan:
- Keys 1,2,A,3,4,E -> echo converts 1,12,3,34; then convert with num=46, error=0, 2 cycles after E.
- Keys 7,B,9,E -> convert num=0, error=1; next key 5 -> convert num=5, error=0, state ENTRY_A.
- Keys 9,9,C,9,9,E -> busy high NUM_W cycles, convert num=9801. Then 1,2,3,C,1,0,0,E -> num=0, error=1 (overflow).
- Keys 9,9,9,9,D,7,E -> num=1428 after NUM_W+1 cycles. Then 1,0,0,D,0,E -> error=1 after 2 cycles.
- Keys 1,2,3,4,5 -> fifth digit ignored, only four converts, num=1234. Then A,C replaces op, 2,E -> num=2468.
- Keys 5,C,6,E, then F on the 3rd COMPUTE cycle -> busy drops next cycle, convert num=0, error=0, no multiply result emitted. rst asserted mid-entry -> all outputs 0 next cycle.
